// File: rtl/fifo_ctrl.sv
// Synchronous FIFO controller driving an external dual-port RAM with a zero-latency read port.
// Holds the pointers and occupancy count. All handshake and RAM-side outputs are decoded combinationally from state.
module fifo_ctrl #(
    parameter int unsigned ADDRESS_BITS = 1,
    parameter int unsigned DATA_BITS    = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    input  logic [DATA_BITS-1:0]    in_data,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [DATA_BITS-1:0]    out_data,
    input  logic                    out_ready,
    output logic [ADDRESS_BITS:0]   level,
    output logic                    ram_write,
    output logic [ADDRESS_BITS-1:0] ram_address_in,
    output logic [ADDRESS_BITS-1:0] ram_address_out,
    output logic [DATA_BITS-1:0]    ram_data_in,
    input  logic [DATA_BITS-1:0]    ram_data_out
);

    localparam int unsigned CNT_W = ADDRESS_BITS + 1;
    localparam int unsigned DEPTH = 1 << ADDRESS_BITS;

    logic [ADDRESS_BITS-1:0] wp;
    logic [ADDRESS_BITS-1:0] rp;
    logic [CNT_W-1:0]        count;
    logic                    push;
    logic                    pop;

    // Ready and valid depend only on count, so there is no fall-through and no pass-through when full.
    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (count != CNT_W'(0));

    // A flush cycle, or reset held asserted, must not write the RAM or consume a word.
    assign push = in_valid & in_ready & ~flush & reset;
    assign pop  = out_valid & out_ready & ~flush;

    assign ram_write       = push;
    assign ram_address_in  = wp;
    assign ram_data_in     = in_data;
    assign ram_address_out = rp;
    assign out_data        = ram_data_out;
    assign level           = count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else if (flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + ADDRESS_BITS'(1);
            if (pop)  rp <= rp + ADDRESS_BITS'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl (ADDRESS_BITS=2, DATA_BITS=8) with a behavioural RAM and a scoreboard queue.
// Each step drives inputs, checks the combinational outputs against a reference model, and then clocks.
module tb_fifo_ctrl;

    logic       clock;
    logic       reset;
    logic       flush;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic [2:0] level;
    logic       ram_write;
    logic [1:0] ram_address_in;
    logic [1:0] ram_address_out;
    logic [7:0] ram_data_in;
    logic [7:0] ram_data_out;

    logic [7:0] mem [4];
    logic [7:0] sb [$];
    int exp_level;
    int exp_wp;
    int exp_rp;
    int vectors;
    int miscompares;

    fifo_ctrl #(.ADDRESS_BITS(2), .DATA_BITS(8)) dut (
        .clock           (clock),
        .reset           (reset),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .in_ready        (in_ready),
        .out_valid       (out_valid),
        .out_data        (out_data),
        .out_ready       (out_ready),
        .level           (level),
        .ram_write       (ram_write),
        .ram_address_in  (ram_address_in),
        .ram_address_out (ram_address_out),
        .ram_data_in     (ram_data_in),
        .ram_data_out    (ram_data_out)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) if (ram_write) mem[ram_address_in] <= ram_data_in;
    assign ram_data_out = mem[ram_address_out];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of stimulus; outputs are checked 1 time unit after the inputs settle, before the edge.
    task automatic step(input logic iv, input logic [7:0] d, input logic ordy, input logic fl);
        logic exp_push;
        logic exp_pop;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        #1;
        exp_push = iv && (exp_level != 4) && !fl;
        exp_pop  = ordy && (exp_level != 0) && !fl;
        chk("in_ready", in_ready, exp_level != 4);
        chk("out_valid", out_valid, exp_level != 0);
        chk("level", level, exp_level);
        chk("ram_write", ram_write, exp_push);
        if (exp_push) begin
            chk("ram_address_in", ram_address_in, exp_wp);
            chk("ram_data_in", ram_data_in, d);
        end
        if (exp_level != 0 && sb.size() > 0) begin
            chk("ram_address_out", ram_address_out, exp_rp);
            chk("out_data", out_data, sb[0]);
        end
        @(posedge clock);
        if (fl) begin
            exp_level = 0;
            exp_wp    = 0;
            exp_rp    = 0;
            sb.delete();
        end else begin
            if (exp_pop && sb.size() > 0) void'(sb.pop_front());
            if (exp_push) sb.push_back(d);
            if (exp_push) exp_wp = (exp_wp + 1) % 4;
            if (exp_pop)  exp_rp = (exp_rp + 1) % 4;
            exp_level = exp_level + (exp_push ? 1 : 0) - (exp_pop ? 1 : 0);
        end
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        exp_level   = 0;
        exp_wp      = 0;
        exp_rp      = 0;
        for (int i = 0; i < 4; i++) mem[i] = 8'hEE;
        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        out_ready = 1'b1;

        // Held in reset with a producer offering data: nothing may be written.
        #12;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_level", level, 0);
        chk("rst_ram_write", ram_write, 1'b0);
        chk("rst_addr_in", ram_address_in, 0);
        chk("rst_addr_out", ram_address_out, 0);
        reset = 1'b1;

        // Three pushes with no consumer.
        step(1'b1, 8'h11, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("lvl3", level, 3);
        chk("head11", out_data, 8'h11);

        // Fill, offer one more while full, then drain in order.
        step(1'b1, 8'h44, 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        // One-at-a-time traffic across pointer wrap.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end

        // Simultaneous handshakes at full and at empty.
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
        step(1'b1, 8'h7F, 1'b1, 1'b0);
        chk("full_both_lvl", level, 3);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'h80, 1'b1, 1'b0);
        chk("empty_both_lvl", level, 1);

        // Flush at level 2 with a push offered.
        step(1'b1, 8'h81, 1'b0, 1'b0);
        step(1'b1, 8'h99, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'h90, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Asynchronous reset between edges at level 3.
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hB0 + i), 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("arst_level", level, 0);
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_in_ready", in_ready, 1'b1);
        chk("arst_addr_out", ram_address_out, 0);
        exp_level = 0;
        exp_wp    = 0;
        exp_rp    = 0;
        sb.delete();
        @(negedge clock);
        reset = 1'b1;
        step(1'b1, 8'hC3, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
